// File: rtl/jam_param.sv
// Exhaustive N x N job-assignment solver walking all N! permutations in lex order.
// Define JAM_BEST_PERM_EN to add the BestPerm output (job of each worker in the best assignment).
module jam_param #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 4,
  localparam int IW = $clog2(N),
  localparam int SW = CW + $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  output logic           busy,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  input  logic [CW-1:0]  Cost,
  output logic [SW-1:0]  MinCost,
  output logic [MCW-1:0] MatchCount,
`ifdef JAM_BEST_PERM_EN
  output logic [N*IW-1:0] BestPerm,
`endif
  output logic           Valid
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    NEXT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]  perm [N];
  logic [IW-1:0]  nxt  [N];
  logic [IW-1:0]  sw   [N];
  logic [IW-1:0]  w_q;
  logic [SW-1:0]  acc;
  logic [SW-1:0]  total;
  logic [SW-1:0]  min_q;
  logic [MCW-1:0] cnt_q;
  logic           last_w;
  logic           desc;
  logic           go;
  int             piv;
  int             kk;
  logic [IW-1:0]  pv;
  logic [IW-1:0]  kv;

`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] perm_flat;
  logic [N*IW-1:0] best_q;
`endif

  assign W          = w_q;
  assign J          = perm[w_q];
  assign MinCost    = min_q;
  assign MatchCount = cnt_q;
  assign last_w     = (w_q == IW'(N - 1));
  assign total      = acc + SW'(Cost);
  assign go         = start && (state == IDLE || state == DONE);

  // Lexicographic successor of perm; desc flags the final (descending) permutation.
  always_comb begin
    piv  = 0;
    pv   = perm[0];
    desc = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        piv  = i;
        pv   = perm[i];
        desc = 1'b0;
      end
    end
    kk = piv;
    kv = pv;
    for (int k = 0; k < N; k++) begin
      if (k > piv && perm[k] > pv) begin
        kk = k;
        kv = perm[k];
      end
    end
    for (int i = 0; i < N; i++) begin
      sw[i] = perm[i];
      if (i == piv)
        sw[i] = kv;
      else if (i == kk)
        sw[i] = pv;
    end
    for (int i = 0; i < N; i++) begin
      nxt[i] = sw[i];
      for (int j = 0; j < N; j++) begin
        if (i > piv && j == N + piv - i)
          nxt[i] = sw[j];
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    Valid    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = ACC;
      end
      ACC: begin
        busy = 1'b1;
        if (last_w)
          state_nx = desc ? DONE : NEXT;
      end
      NEXT: begin
        busy     = 1'b1;
        state_nx = ACC;
      end
      DONE: begin
        Valid = 1'b1;
        if (start)
          state_nx = ACC;
      end
    endcase
  end

  // Permutation, accumulator and result registers.
  always_ff @(posedge CLK) begin
    if (RST || go) begin
      for (int i = 0; i < N; i++)
        perm[i] <= IW'(i);
      w_q   <= '0;
      acc   <= '0;
      min_q <= '1;
      cnt_q <= '0;
    end else begin
      if (state == ACC) begin
        if (!last_w) begin
          acc <= total;
          w_q <= w_q + IW'(1);
        end else begin
          if (total < min_q) begin
            min_q <= total;
            cnt_q <= MCW'(1);
          end else if (total == min_q && cnt_q != '1) begin
            cnt_q <= cnt_q + MCW'(1);
          end
          w_q <= '0;
          acc <= '0;
        end
      end
      if (state == NEXT) begin
        for (int i = 0; i < N; i++)
          perm[i] <= nxt[i];
      end
    end
  end

`ifdef JAM_BEST_PERM_EN
  // Flatten perm so it can be captured as a single word.
  always_comb begin
    perm_flat = '0;
    for (int i = 0; i < N; i++)
      perm_flat[i*IW +: IW] = perm[i];
  end

  // Capture the assignment on every strict improvement; ties keep the earlier one.
  always_ff @(posedge CLK) begin
    if (RST || go)
      best_q <= '0;
    else if (state == ACC && last_w && total < min_q)
      best_q <= perm_flat;
  end

  assign BestPerm = best_q;
`endif

endmodule
